// File: rtl/part_3_demux_if.sv
// Bus bundle between the part_3 serial line/select source and the demux.
// The source side drives the line, select code and enable; the demux side
// returns the committed channel values and frame status.
interface part_3_demux_if #(
  parameter int CNT_W = 8
);
  logic             T;
  logic             S0;
  logic             S1;
  logic             en;
  logic             X;
  logic             Y;
  logic             Z;
  logic             valid;
  logic             err;
  logic [CNT_W-1:0] frame_cnt;

  modport master (
    output T, S0, S1, en,
    input  X, Y, Z, valid, err, frame_cnt
  );

  modport slave (
    input  T, S0, S1, en,
    output X, Y, Z, valid, err, frame_cnt
  );
endinterface

// File: rtl/part_3_demux.sv
// part_3_demux: rebuilds the X/Y/Z channels from the part_3 serial line.
// Each select code 00/01/10 captures T into a shadow register and marks that
// channel as captured; code 11 commits the shadow frame to the outputs only
// when all three channels were captured since the last commit, otherwise it
// raises a sticky error. All outputs are registered.
module part_3_demux #(
  parameter int CNT_W = 8
) (
  input  logic          Clk,
  input  logic          synch_reset,
  part_3_demux_if.slave bus
);

  // COLLECT: frame still missing at least one channel; READY: all captured.
  typedef enum logic {
    COLLECT = 1'b0,
    READY   = 1'b1
  } state_t;

  state_t           state_r;
  logic             sx_r;
  logic             sy_r;
  logic             sz_r;
  logic [2:0]       mask_r;
  logic             x_r;
  logic             y_r;
  logic             z_r;
  logic             valid_r;
  logic             err_r;
  logic [CNT_W-1:0] frame_cnt_r;

  logic [2:0]       cap_sel_s;
  logic             commit_s;
  logic [2:0]       mask_next_s;

  // True once every channel of the frame has been captured.
  function automatic logic mask_full(input logic [2:0] m);
    return (m == 3'b111);
  endfunction

  // Decode the sampled select code into a one-hot capture strobe or a commit.
  always_comb begin
    cap_sel_s = 3'b000;
    commit_s  = 1'b0;
    if (bus.en) begin
      case ({bus.S1, bus.S0})
        2'b00:   cap_sel_s = 3'b001;
        2'b01:   cap_sel_s = 3'b010;
        2'b10:   cap_sel_s = 3'b100;
        2'b11:   commit_s  = 1'b1;
        default: begin
          cap_sel_s = 3'b000;
          commit_s  = 1'b0;
        end
      endcase
    end else begin
      cap_sel_s = 3'b000;
      commit_s  = 1'b0;
    end
  end

  // Capture mask after this edge's capture, used to decide COLLECT->READY.
  always_comb begin
    mask_next_s = mask_r | cap_sel_s;
  end

  // Sequencer, shadow capture and registered outputs in a single state update.
  always_ff @(posedge Clk) begin
    if (synch_reset) begin
      state_r     <= COLLECT;
      sx_r        <= 1'b0;
      sy_r        <= 1'b0;
      sz_r        <= 1'b0;
      mask_r      <= 3'b000;
      x_r         <= 1'b0;
      y_r         <= 1'b0;
      z_r         <= 1'b0;
      valid_r     <= 1'b0;
      err_r       <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      // valid is a single-cycle pulse; only a good commit raises it.
      valid_r <= 1'b0;
      if (commit_s) begin
        if (state_r == READY) begin
          x_r         <= sx_r;
          y_r         <= sy_r;
          z_r         <= sz_r;
          valid_r     <= 1'b1;
          frame_cnt_r <= frame_cnt_r + CNT_W'(1);
        end else begin
          // Commit of a partial frame: outputs untouched, error latched.
          err_r <= 1'b1;
        end
        // Every commit, good or bad, starts a fresh frame. Shadows are kept.
        mask_r  <= 3'b000;
        state_r <= COLLECT;
      end else if (cap_sel_s != 3'b000) begin
        // Recapture of a channel simply overwrites its shadow register.
        if (cap_sel_s[0]) begin
          sx_r <= bus.T;
        end else begin
          sx_r <= sx_r;
        end
        if (cap_sel_s[1]) begin
          sy_r <= bus.T;
        end else begin
          sy_r <= sy_r;
        end
        if (cap_sel_s[2]) begin
          sz_r <= bus.T;
        end else begin
          sz_r <= sz_r;
        end
        mask_r <= mask_next_s;
        case (state_r)
          COLLECT: state_r <= mask_full(mask_next_s) ? READY : COLLECT;
          READY:   state_r <= READY;
          default: state_r <= COLLECT;
        endcase
      end else begin
        // en low: every register holds, valid already cleared above.
        state_r <= state_r;
        mask_r  <= mask_r;
      end
    end
  end

  assign bus.X         = x_r;
  assign bus.Y         = y_r;
  assign bus.Z         = z_r;
  assign bus.valid     = valid_r;
  assign bus.err       = err_r;
  assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_part_3_demux.sv
// Self-checking bench for part_3_demux: directed scenarios plus a timed
// pattern sweep and a random sweep, all compared edge by edge against a
// frame-level reference model.
module tb_part_3_demux;

  localparam int CNT_W = 2;

  logic Clk;
  logic synch_reset;
  int   tests;
  int   fails;
  logic prev_valid;

  // Reference model: per-channel shadow values and "captured" flags.
  bit   m_sh  [3];
  bit   m_cap [3];
  bit   m_x, m_y, m_z, m_valid, m_err;
  int   m_cnt;

  part_3_demux_if #(.CNT_W(CNT_W)) bus ();

  part_3_demux #(.CNT_W(CNT_W)) dut (
    .Clk         (Clk),
    .synch_reset (synch_reset),
    .bus         (bus)
  );

  initial Clk = 1'b0;
  always #9 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply the frame rules to the model for one rising edge.
  task automatic model_edge(input logic t, input logic [1:0] sel, input logic e, input logic r);
    int ch;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        m_sh[i]  = 1'b0;
        m_cap[i] = 1'b0;
      end
      {m_x, m_y, m_z, m_valid, m_err} = 5'b00000;
      m_cnt = 0;
    end else if (!e) begin
      m_valid = 1'b0;
    end else begin
      m_valid = 1'b0;
      ch = int'(sel);
      if (ch < 3) begin
        m_sh[ch]  = t;
        m_cap[ch] = 1'b1;
      end else begin
        if (m_cap[0] && m_cap[1] && m_cap[2]) begin
          m_x     = m_sh[0];
          m_y     = m_sh[1];
          m_z     = m_sh[2];
          m_valid = 1'b1;
          m_cnt   = (m_cnt + 1) % (1 << CNT_W);
        end else begin
          m_err = 1'b1;
        end
        for (int i = 0; i < 3; i++) m_cap[i] = 1'b0;
      end
    end
  endtask

  // Called at a falling edge: drive, take one rising edge, check 1 ns later,
  // then return at the next falling edge.
  task automatic step(input logic t, input logic [1:0] sel, input logic e, input logic r);
    bus.T       = t;
    bus.S1      = sel[1];
    bus.S0      = sel[0];
    bus.en      = e;
    synch_reset = r;
    @(posedge Clk);
    model_edge(t, sel, e, r);
    #1;
    chk("X", 32'(bus.X), 32'(m_x));
    chk("Y", 32'(bus.Y), 32'(m_y));
    chk("Z", 32'(bus.Z), 32'(m_z));
    chk("valid", 32'(bus.valid), 32'(m_valid));
    chk("err", 32'(bus.err), 32'(m_err));
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
    chk("valid_twice", 32'(prev_valid && bus.valid), 32'd0);
    prev_valid = bus.valid;
    @(negedge Clk);
  endtask

  initial begin
    logic [2:0] bits;
    time        t_now;
    tests       = 0;
    fails       = 0;
    prev_valid  = 1'b0;
    synch_reset = 1'b1;
    bus.T       = 1'b0;
    bus.S0      = 1'b0;
    bus.S1      = 1'b0;
    bus.en      = 1'b0;
    @(negedge Clk);

    // Reset for three edges with T=1, sel=00.
    for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 1'b1, 1'b1);
    chk("rst_xyz", 32'({bus.X, bus.Y, bus.Z}), 32'd0);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_cnt", 32'(bus.frame_cnt), 32'd0);

    // Full frame 101.
    step(1'b1, 2'b00, 1'b1, 1'b0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b11, 1'b1, 1'b0);
    chk("full_xyz", 32'({bus.X, bus.Y, bus.Z}), 32'b101);
    chk("full_valid", 32'(bus.valid), 32'd1);
    chk("full_cnt", 32'(bus.frame_cnt), 32'd1);
    chk("full_err", 32'(bus.err), 32'd0);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    chk("full_valid_drop", 32'(bus.valid), 32'd0);

    // Incomplete commit, then a good frame 011 with err staying set.
    step(1'b0, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b11, 1'b1, 1'b0);
    chk("inc_xyz", 32'({bus.X, bus.Y, bus.Z}), 32'd0);
    chk("inc_valid", 32'(bus.valid), 32'd0);
    chk("inc_err", 32'(bus.err), 32'd1);
    step(1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b0, 2'b11, 1'b1, 1'b0);
    chk("inc2_xyz", 32'({bus.X, bus.Y, bus.Z}), 32'b011);
    chk("inc2_valid", 32'(bus.valid), 32'd1);
    chk("inc2_err", 32'(bus.err), 32'd1);
    chk("inc2_cnt", 32'(bus.frame_cnt), 32'd1);

    // Enable hold and overwrite.
    step(1'b0, 2'b00, 1'b1, 1'b1);
    step(1'b1, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2'b11, 1'b0, 1'b0);
      chk("hold_valid", 32'(bus.valid), 32'd0);
      chk("hold_cnt", 32'(bus.frame_cnt), 32'd0);
    end
    step(1'b0, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b1, 2'b10, 1'b1, 1'b0);
    step(1'b1, 2'b11, 1'b1, 1'b0);
    chk("ovr_xyz", 32'({bus.X, bus.Y, bus.Z}), 32'b011);
    chk("ovr_valid", 32'(bus.valid), 32'd1);
    chk("ovr_err", 32'(bus.err), 32'd0);
    step(1'b0, 2'b01, 1'b1, 1'b0);
    chk("ovr_valid_drop", 32'(bus.valid), 32'd0);

    // Counter wrap over four good frames, then reset mid-frame.
    step(1'b0, 2'b00, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bits = 3'($urandom_range(0, 7));
      step(bits[2], 2'b00, 1'b1, 1'b0);
      step(bits[1], 2'b01, 1'b1, 1'b0);
      step(bits[0], 2'b10, 1'b1, 1'b0);
      step(1'b0, 2'b11, 1'b1, 1'b0);
      chk("wrap_cnt", 32'(bus.frame_cnt), 32'((i + 1) % 4));
      chk("wrap_xyz", 32'({bus.X, bus.Y, bus.Z}), 32'(bits));
    end
    step(1'b1, 2'b00, 1'b1, 1'b0);
    step(1'b1, 2'b01, 1'b1, 1'b0);
    step(1'b0, 2'b00, 1'b1, 1'b1);
    step(1'b0, 2'b11, 1'b1, 1'b0);
    chk("midrst_err", 32'(bus.err), 32'd1);
    chk("midrst_cnt", 32'(bus.frame_cnt), 32'd0);
    chk("midrst_valid", 32'(bus.valid), 32'd0);

    // Timed pattern sweep: T every 15 ns, select every 23 ns, reset every 105 ns.
    for (int i = 0; i < 80; i++) begin
      t_now = $time;
      step(1'((t_now / 15) % 2), 2'((t_now / 23) % 4), 1'b1, (t_now % 105) < 18);
    end

    // Random sweep.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 40) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
